// File: rtl/aes_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : aes_axil_slave
// Brief    : AXI4-Lite register front end for a 128-bit AES core. Holds the
//            key and data-in words, issues the start pulse, captures the
//            result words and reports busy/done status.
// Revision : 1.0 - initial release
// ============================================================================
module aes_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // AES core command
  output logic                            core_start,
  output logic                            core_decrypt,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] core_key,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] core_din,
  // AES core result
  input  logic                            core_done,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0] core_dout
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  wr_state_t        wr_state, wr_state_nxt;
  rd_state_t        rd_state, rd_state_nxt;

  logic             aw_done, w_done;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0]    wdata_q;
  logic [SW-1:0]    wstrb_q;
  logic [1:0]       bresp_q;
  logic [DW-1:0]    rdata_q;

  logic             decrypt_q, busy_q, done_q, start_q;
  logic [DW-1:0]    key_q  [4];
  logic [DW-1:0]    din_q  [4];
  logic [DW-1:0]    dout_q [4];

  logic             commit;
  logic             is_ctrl, is_status, is_key, is_din, is_dout;
  logic             start_req, wr_err;
  logic [1:0]       wr_sel;
  logic [IDX_W-1:0] ar_idx;
  logic [DW-1:0]    rd_word;
  logic             unused_bits;

  // Byte-lane merge of a write into an existing register value
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Handshake readiness; held low while reset is asserted
  assign S_AXI_AWREADY = !ARESET && (wr_state == W_IDLE) && !aw_done;
  assign S_AXI_WREADY  = !ARESET && (wr_state == W_IDLE) && !w_done;
  assign S_AXI_ARREADY = !ARESET && (rd_state == R_IDLE);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rd_state == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;

  assign core_start   = start_q;
  assign core_decrypt = decrypt_q;
  assign core_key     = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign core_din     = {din_q[0], din_q[1], din_q[2], din_q[3]};

  // Protection bits and byte-offset address bits carry no meaning here
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Register write happens the cycle after both address and data are held
  assign commit = (wr_state == W_IDLE) && aw_done && w_done;

  // Write decode and error classification for the captured transaction
  always_comb begin
    is_ctrl   = (aw_idx == IDX_W'(0));
    is_status = (aw_idx == IDX_W'(1));
    is_key    = (aw_idx >= IDX_W'(2))  && (aw_idx <= IDX_W'(5));
    is_din    = (aw_idx >= IDX_W'(6))  && (aw_idx <= IDX_W'(9));
    is_dout   = (aw_idx >= IDX_W'(10)) && (aw_idx <= IDX_W'(13));
    wr_sel    = 2'(aw_idx - (is_key ? IDX_W'(2) : IDX_W'(6)));
    start_req = is_ctrl && wstrb_q[0] && wdata_q[0];
    wr_err    = is_dout || ((is_key || is_din || start_req) && busy_q);
  end

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM next state
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_done && w_done) wr_state_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY)      wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Capture address and data independently, in either order
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (commit) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_done <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_done  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Write response code, held until the response is taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)      bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
  end

  // Register file, start pulse and core completion handling
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      decrypt_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      start_q <= 1'b0;
      if (commit && !wr_err) begin
        if (is_ctrl && wstrb_q[0]) decrypt_q <= wdata_q[1];
        if (start_req) begin
          start_q <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        if (is_status && wstrb_q[0] && wdata_q[1]) done_q <= 1'b0;
        if (is_key) key_q[wr_sel] <= merge_bytes(key_q[wr_sel], wdata_q, wstrb_q);
        if (is_din) din_q[wr_sel] <= merge_bytes(din_q[wr_sel], wdata_q, wstrb_q);
      end
      // Completion is placed last so a same-cycle DONE clear loses to it
      if (core_done && busy_q) begin
        for (int i = 0; i < 4; i++) dout_q[i] <= core_dout[DW*(3-i) +: DW];
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Read data selection from pre-edge register contents
  always_comb begin
    rd_word = '0;
    if (ar_idx == IDX_W'(0)) begin
      rd_word[1] = decrypt_q;
    end else if (ar_idx == IDX_W'(1)) begin
      rd_word[0] = busy_q;
      rd_word[1] = done_q;
    end else if (ar_idx <= IDX_W'(5)) begin
      rd_word = key_q[2'(ar_idx - IDX_W'(2))];
    end else if (ar_idx <= IDX_W'(9)) begin
      rd_word = din_q[2'(ar_idx - IDX_W'(6))];
    end else if (ar_idx <= IDX_W'(13)) begin
      rd_word = dout_q[2'(ar_idx - IDX_W'(10))];
    end
  end

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Read FSM next state
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (S_AXI_ARVALID) rd_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY)  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read data latched on the address handshake and held until taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                               rdata_q <= '0;
    else if (S_AXI_ARVALID && S_AXI_ARREADY)  rdata_q <= rd_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_axil_slave
// Brief    : Scoreboard testbench for aes_axil_slave. Drivers queue the
//            expected write responses and read data; a monitor pops and
//            compares whenever a response handshake is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_axil_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         areset;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         core_start, core_decrypt, core_done;
  logic [127:0] core_key, core_din, core_dout;

  int           errors = 0;
  int           checks = 0;
  int           start_cnt = 0;
  logic [1:0]   bq[$];
  logic [31:0]  rq[$];

  aes_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(clk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_decrypt(core_decrypt), .core_key(core_key), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=no handshake expected=handshake within bound", name);
  endtask

  // Monitor: compare each presented response against the scoreboard head
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual=bvalid expected=no response");
      end else check("bresp", {126'b0, bresp}, {126'b0, bq.pop_front()});
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected actual=rvalid expected=no response");
      end else begin
        check("rdata", {96'b0, rdata}, {96'b0, rq.pop_front()});
        check("rresp", {126'b0, rresp}, 128'd0);
      end
    end
    if (core_start) start_cnt++;
  end

  task automatic wait_b_drain();
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (bq.size() == 0) break;
    end
    if (bq.size() != 0) begin timeout("b_timeout"); bq.delete(); end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp);
    logic aw_ok, w_ok, aw_hs, w_hs;
    bq.push_back(exp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0;
    for (int n = 0; n < 50 && !(aw_ok && w_ok); n++) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_ok = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_ok  = 1'b1; end
    end
    if (!(aw_ok && w_ok)) begin
      timeout("aw_w_timeout"); awvalid = 1'b0; wvalid = 1'b0; bq.delete();
    end else wait_b_drain();
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp);
    logic ok, hs;
    rq.push_back(exp);
    araddr = a; arvalid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin arvalid = 1'b0; ok = 1'b1; end
    end
    if (!ok) begin timeout("ar_timeout"); arvalid = 1'b0; rq.delete(); end
    else begin
      for (int n = 0; n < 50; n++) begin
        @(posedge clk); #1;
        if (rq.size() == 0) break;
      end
      if (rq.size() != 0) begin timeout("r_timeout"); rq.delete(); end
    end
  endtask

  task automatic pulse_done(input logic [127:0] d);
    @(posedge clk); #1;
    core_done = 1'b1; core_dout = d;
    @(posedge clk); #1;
    core_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  s0;
    logic ok, hs;
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    core_done = 1'b0; core_dout = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", {127'b0, awready}, 128'd0);
    check("rst_wready",  {127'b0, wready},  128'd0);
    check("rst_arready", {127'b0, arready}, 128'd0);
    check("rst_bvalid",  {127'b0, bvalid},  128'd0);
    check("rst_rvalid",  {127'b0, rvalid},  128'd0);
    check("rst_rdata",   {96'b0, rdata},    128'd0);
    check("rst_core_start", {127'b0, core_start}, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    @(posedge clk); #1;
    areset = 1'b0;

    // Key load and readback
    for (int i = 0; i < 4; i++) axi_write(6'(8 + 4*i), 32'(i + 1), 4'hF, OKAY);
    for (int i = 0; i < 4; i++) axi_read(6'(8 + 4*i), 32'(i + 1));
    check("core_key", core_key, 128'h00000001_00000002_00000003_00000004);
    axi_read(6'h00, 32'h0);
    axi_read(6'h04, 32'h0);

    // Data arrives early, response back-pressured, partial strobe
    bq.push_back(OKAY);
    bready = 1'b0; awaddr = 6'h18; wdata = 32'hAABBCCDD; wstrb = 4'h3; wvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) begin wvalid = 1'b0; ok = 1'b1; end
    end
    check("w_early_accept", {127'b0, ok}, 128'd1);
    wvalid = 1'b0; awvalid = 1'b1; ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1;
      if (hs) begin awvalid = 1'b0; ok = 1'b1; end
    end
    if (!ok) begin timeout("aw_late_timeout"); awvalid = 1'b0; end
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bvalid;
    end
    if (!ok) timeout("bvalid_timeout");
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk);
      check("bvalid_hold", {127'b0, bvalid}, 128'd1);
      check("bresp_hold",  {126'b0, bresp},  128'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b_drain();
    repeat (4) @(posedge clk);
    #1;
    axi_read(6'h18, 32'h0000CCDD);
    check("core_din0", {96'b0, core_din[127:96]}, 128'h0000CCDD);

    // Decrypt bit, start pulse and busy-time protection
    axi_write(6'h00, 32'h2, 4'hF, OKAY);
    axi_read(6'h00, 32'h2);
    check("core_decrypt_set", {127'b0, core_decrypt}, 128'd1);
    s0 = start_cnt;
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    check("start_pulse_cnt", 128'(start_cnt - s0), 128'd1);
    axi_read(6'h04, 32'h1);
    axi_read(6'h00, 32'h0);
    axi_write(6'h08, 32'hDEADBEEF, 4'hF, SLVERR);
    axi_read(6'h08, 32'h1);
    axi_write(6'h1C, 32'h12345678, 4'hF, SLVERR);
    axi_write(6'h28, 32'h12345678, 4'hF, SLVERR);

    // Completion captures the result
    pulse_done(128'h00112233_44556677_8899AABB_CCDDEEFF);
    axi_read(6'h04, 32'h2);
    axi_read(6'h28, 32'h00112233);
    axi_read(6'h2C, 32'h44556677);
    axi_read(6'h34, 32'hCCDDEEFF);
    axi_write(6'h04, 32'h2, 4'hF, OKAY);
    axi_read(6'h04, 32'h0);

    // Reserved words and empty strobe
    axi_write(6'h38, 32'hFFFFFFFF, 4'hF, OKAY);
    axi_read(6'h38, 32'h0);
    axi_write(6'h0C, 32'hFFFFFFFF, 4'h0, OKAY);
    axi_read(6'h0C, 32'h2);

    // START committed on the same edge as core_done
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    s0 = start_cnt;
    bq.push_back(SLVERR);
    awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("coinc_ready", {126'b0, awready, wready}, 128'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    core_done = 1'b1; core_dout = {4{32'hA5A5A5A5}};
    @(posedge clk); #1;
    core_done = 1'b0;
    wait_b_drain();
    check("coinc_no_start", 128'(start_cnt - s0), 128'd0);
    axi_read(6'h04, 32'h2);
    axi_read(6'h28, 32'hA5A5A5A5);
    // Completion while idle is ignored
    pulse_done({4{32'h5A5A5A5A}});
    axi_read(6'h28, 32'hA5A5A5A5);
    axi_read(6'h04, 32'h2);

    // Asynchronous reset while busy
    axi_write(6'h00, 32'h3, 4'hF, OKAY);
    check("busy_decrypt", {127'b0, core_decrypt}, 128'd1);
    @(posedge clk); #3;
    areset = 1'b1;
    #1;
    check("arst_core_key",     core_key, 128'd0);
    check("arst_core_din",     core_din, 128'd0);
    check("arst_core_decrypt", {127'b0, core_decrypt}, 128'd0);
    check("arst_readys",       {125'b0, awready, wready, arready}, 128'd0);
    check("arst_valids",       {126'b0, bvalid, rvalid}, 128'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    pulse_done({4{32'hFFFFFFFF}});
    axi_read(6'h04, 32'h0);
    axi_read(6'h28, 32'h0);
    axi_read(6'h08, 32'h0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
